// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and word/address types for the register file
package regfile_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xword_t;
endpackage

// File: rtl/regfile_scoreboard_busy.sv
// rtl/regfile_scoreboard_busy.sv - per-register pending-writer bits and read-port hazard lookup
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_v;
    logic [NREGS-1:0] clr_v;
    logic [AW-1:0]    ra;

    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int a = 0; a < NREGS; a++) begin
            set_v[a] = iss_en && (iss_addr == AW'(a)) && !(ZERO_REG != 0 && a == 0);
            clr_v[a] = wr_en && (wr_addr == AW'(a));
        end
    end

    // set is applied after clear so a new producer issuing in the writeback cycle keeps the bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_v) | set_v;
        end
    end

    always_comb begin
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (int'(ra) < NREGS && !(ZERO_REG != 0 && ra == '0)) begin
                rd_busy[i] = busy[ra] && !(wr_en && wr_addr == ra);
            end
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with registered read ports, write bypass and busy scoreboard
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr
);
    logic [XLEN-1:0]     mem [NREGS];
    logic                wr_ok;
    logic [NRD*XLEN-1:0] rd_next;
    logic [AW-1:0]       ra;

    assign wr_ok = wr_en && (int'(wr_addr) < NREGS) && !(ZERO_REG != 0 && wr_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // write-first: a value landing this cycle is what the read returns
    always_comb begin
        rd_next = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (int'(ra) >= NREGS || (ZERO_REG != 0 && ra == '0)) begin
                rd_next[i*XLEN +: XLEN] = '0;
            end else if (wr_ok && wr_addr == ra) begin
                rd_next[i*XLEN +: XLEN] = wr_data;
            end else begin
                rd_next[i*XLEN +: XLEN] = mem[ra];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );
endmodule
